// File: rtl/ula_multiciclo_ctrl.sv
// Multicycle control FSM for the 8-bit ULA datapath of the RISC-V subset core.
// Sources ULAControl, operand-select muxes and all write enables; resolves beq/bne from Z.
module ula_multiciclo_ctrl #(
  parameter int ST_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [6:0]      op,
  input  logic [2:0]      funct3,
  input  logic            funct7b5,
  input  logic            Z,
  output logic            PCWrite,
  output logic            AdrSrc,
  output logic            MemWrite,
  output logic            IRWrite,
  output logic            RegWrite,
  output logic [1:0]      ResultSrc,
  output logic [1:0]      ULASrcA,
  output logic [1:0]      ULASrcB,
  output logic [1:0]      ImmSrc,
  output logic [2:0]      ULAControl,
  output logic            Illegal,
  output logic [ST_W-1:0] StateOut
);

  typedef enum logic [ST_W-1:0] {
    FETCH    = ST_W'(0),
    DECODE   = ST_W'(1),
    MEMADR   = ST_W'(2),
    MEMREAD  = ST_W'(3),
    MEMWB    = ST_W'(4),
    MEMWRITE = ST_W'(5),
    EXECUTER = ST_W'(6),
    EXECUTEI = ST_W'(7),
    ALUWB    = ST_W'(8),
    BRANCH   = ST_W'(9),
    JAL      = ST_W'(10),
    ILLEGAL  = ST_W'(15)
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_FUNCT
  } alu_op_t;

  state_t      state, next_state;
  alu_op_t     alu_op;
  logic [2:0]  funct_ctl;
  logic        funct_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // funct3 decode for R/I ALU ops; funct_ok also gates DECODE -> EXECUTE.
  always_comb begin
    funct_ctl = 3'b000;
    funct_ok  = 1'b1;
    case (funct3)
      3'b000:  funct_ctl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
      3'b010:  funct_ctl = 3'b101;
      3'b100:  funct_ctl = 3'b100;
      3'b110:  funct_ctl = 3'b011;
      3'b111:  funct_ctl = 3'b010;
      default: funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    case (alu_op)
      ALU_SUB:   ULAControl = 3'b001;
      ALU_FUNCT: ULAControl = funct_ctl;
      default:   ULAControl = 3'b000;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011: ImmSrc = 2'b01;
      7'b1100011: ImmSrc = 2'b10;
      7'b1101111: ImmSrc = 2'b11;
      default:    ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    next_state = state;
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegWrite   = 1'b0;
    ResultSrc  = 2'b00;
    ULASrcA    = 2'b00;
    ULASrcB    = 2'b00;
    alu_op     = ALU_ADD;
    Illegal    = 1'b0;
    case (state)
      FETCH: begin
        IRWrite    = 1'b1;
        ULASrcB    = 2'b10;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        next_state = DECODE;
      end
      DECODE: begin
        ULASrcA = 2'b01;
        ULASrcB = 2'b01;
        case (op)
          7'b0000011, 7'b0100011: next_state = MEMADR;
          7'b0110011:             next_state = funct_ok ? EXECUTER : ILLEGAL;
          7'b0010011:             next_state = funct_ok ? EXECUTEI : ILLEGAL;
          7'b1100011:             next_state = (funct3[2:1] == 2'b00) ? BRANCH : ILLEGAL;
          7'b1101111:             next_state = JAL;
          default:                next_state = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ULASrcA    = 2'b10;
        ULASrcB    = 2'b01;
        next_state = op[5] ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc     = 1'b1;
        next_state = MEMWB;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        MemWrite   = 1'b1;
        next_state = FETCH;
      end
      EXECUTER: begin
        ULASrcA    = 2'b10;
        alu_op     = ALU_FUNCT;
        next_state = ALUWB;
      end
      EXECUTEI: begin
        ULASrcA    = 2'b10;
        ULASrcB    = 2'b01;
        alu_op     = ALU_FUNCT;
        next_state = ALUWB;
      end
      ALUWB: begin
        RegWrite   = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        ULASrcA    = 2'b10;
        alu_op     = ALU_SUB;
        PCWrite    = funct3[0] ? ~Z : Z;
        next_state = FETCH;
      end
      JAL: begin
        ULASrcA    = 2'b01;
        ULASrcB    = 2'b10;
        PCWrite    = 1'b1;
        next_state = ALUWB;
      end
      ILLEGAL: begin
        Illegal    = 1'b1;
        next_state = ILLEGAL;
      end
      default: next_state = ILLEGAL;
    endcase
  end

  assign StateOut = state;

endmodule

// File: tb/tb_ula_multiciclo_ctrl.sv
// Scoreboard bench for ula_multiciclo_ctrl: stimulus queues hand-computed per-cycle
// output vectors, a negedge monitor pops and compares them against the DUT.
module tb_ula_multiciclo_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Z;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
  logic [1:0] ResultSrc, ULASrcA, ULASrcB, ImmSrc;
  logic [2:0] ULAControl;
  logic [3:0] StateOut;

  ula_multiciclo_ctrl #(.ST_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5), .Z(Z),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ULASrcA(ULASrcA), .ULASrcB(ULASrcB),
    .ImmSrc(ImmSrc), .ULAControl(ULAControl), .Illegal(Illegal), .StateOut(StateOut)
  );

  always #5 clk = ~clk;

  // {state, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ULASrcA, ULASrcB, ImmSrc, ULAControl, Illegal}
  typedef struct {
    logic [20:0] v;
    string       tag;
    int          idx;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  int          seq = 0;
  string       tag = "";
  logic [1:0]  cur_imm = 2'b00;

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [20:0] act;
      e = sb.pop_front();
      act = {StateOut, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
             ULASrcA, ULASrcB, ImmSrc, ULAControl, Illegal};
      checks++;
      if (act !== e.v) begin
        failures++;
        $display("FAIL %s[%0d] got=%06h (st=%0d) expected=%06h (st=%0d)",
                 e.tag, e.idx, act, act[20:17], e.v, e.v[20:17]);
      end
    end
  end

  task automatic cyc(input logic [3:0] st, input logic pcw, input logic adr, input logic mw,
                     input logic irw, input logic rw, input logic [1:0] rs, input logic [1:0] sa,
                     input logic [1:0] sb_sel, input logic [2:0] alu, input logic ill);
    exp_t e;
    e.v   = {st, pcw, adr, mw, irw, rw, rs, sa, sb_sel, cur_imm, alu, ill};
    e.tag = tag;
    e.idx = seq++;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic instr(input string name, input logic [6:0] o, input logic [2:0] f3,
                       input logic f7, input logic [1:0] imm);
    tag      = name;
    seq      = 0;
    op       = o;
    funct3   = f3;
    funct7b5 = f7;
    cur_imm  = imm;
  endtask

  task automatic c_fetch();  cyc(4'd0, 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 3'b000, 0); endtask
  task automatic c_decode(); cyc(4'd1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 3'b000, 0); endtask
  task automatic c_aluwb();  cyc(4'd8, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 3'b000, 0); endtask
  task automatic c_ill();    cyc(4'd15, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 1); endtask

  initial begin
    rst_n = 1'b0; Z = 1'b0;
    instr("reset_lw", 7'b0000011, 3'b010, 1'b0, 2'b00);
    @(posedge clk); #1;
    c_fetch();                      // held in reset
    rst_n = 1'b1;
    c_fetch();
    c_decode();
    cyc(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    cyc(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    cyc(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0);

    instr("sw", 7'b0100011, 3'b010, 1'b0, 2'b01);
    c_fetch(); c_decode();
    cyc(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    cyc(4'd5, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);

    instr("r_sub", 7'b0110011, 3'b000, 1'b1, 2'b00);
    Z = 1'b1;
    c_fetch(); c_decode();
    cyc(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
    c_aluwb();
    Z = 1'b0;

    instr("i_add_f7", 7'b0010011, 3'b000, 1'b1, 2'b00);
    c_fetch(); c_decode();
    cyc(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    c_aluwb();

    instr("r_and", 7'b0110011, 3'b111, 1'b0, 2'b00);
    c_fetch(); c_decode();
    cyc(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b010, 0);
    c_aluwb();

    instr("r_or", 7'b0110011, 3'b110, 1'b0, 2'b00);
    c_fetch(); c_decode();
    cyc(4'd6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b011, 0);
    c_aluwb();

    instr("i_xor", 7'b0010011, 3'b100, 1'b0, 2'b00);
    c_fetch(); c_decode();
    cyc(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b100, 0);
    c_aluwb();

    instr("i_slt", 7'b0010011, 3'b010, 1'b0, 2'b00);
    c_fetch(); c_decode();
    cyc(4'd7, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b101, 0);
    c_aluwb();

    instr("beq_z1", 7'b1100011, 3'b000, 1'b0, 2'b10);
    c_fetch(); c_decode(); Z = 1'b1;
    cyc(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
    instr("beq_z0", 7'b1100011, 3'b000, 1'b0, 2'b10);
    c_fetch(); c_decode(); Z = 1'b0;
    cyc(4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
    instr("bne_z1", 7'b1100011, 3'b001, 1'b0, 2'b10);
    c_fetch(); c_decode(); Z = 1'b1;
    cyc(4'd9, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);
    instr("bne_z0", 7'b1100011, 3'b001, 1'b0, 2'b10);
    c_fetch(); c_decode(); Z = 1'b0;
    cyc(4'd9, 1, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 3'b001, 0);

    instr("jal", 7'b1101111, 3'b000, 1'b0, 2'b11);
    c_fetch(); c_decode();
    cyc(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);
    c_aluwb();

    instr("lw_rst_mid", 7'b0000011, 3'b010, 1'b0, 2'b00);
    c_fetch(); c_decode();
    cyc(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    rst_n = 1'b0;
    c_fetch();
    rst_n = 1'b1;
    c_fetch(); c_decode();
    cyc(4'd2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 3'b000, 0);
    cyc(4'd3, 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 3'b000, 0);
    cyc(4'd4, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 3'b000, 0);

    instr("br_bad_f3", 7'b1100011, 3'b010, 1'b0, 2'b10);
    c_fetch(); c_decode(); c_ill();
    rst_n = 1'b0;
    instr("bad_op", 7'b1111111, 3'b000, 1'b0, 2'b00);
    c_fetch();
    rst_n = 1'b1;
    c_fetch(); c_decode(); c_ill();
    rst_n = 1'b0;
    instr("r_bad_f3", 7'b0110011, 3'b001, 1'b0, 2'b00);
    c_fetch();
    rst_n = 1'b1;
    c_fetch(); c_decode();
    Z = 1'b1;
    for (int i = 0; i < 10; i++) c_ill();
    rst_n = 1'b0;
    c_fetch();
    rst_n = 1'b1;
    instr("after_ill", 7'b1101111, 3'b000, 1'b0, 2'b11);
    c_fetch(); c_decode();
    cyc(4'd10, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 3'b000, 0);

    @(negedge clk); #1;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0 pending entries", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
